// File: rtl/noc_rx_dma.sv
// Receive DMA for the tile network interface.
// Stores one packet at a time (header, size, payload) into the tile RAM
// through port B. When the packet is complete it raises a level interrupt
// and holds the buffer until the CPU acknowledges it.
module noc_rx_dma #(
    parameter logic [31:0] BUF_BASE  = 32'h0000_E000,
    parameter int unsigned BUF_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    output logic        mem_enable_out,
    output logic [3:0]  mem_wb_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_data_out,
    output logic        irq_out,
    input  logic        cpu_ack_in,
    output logic [31:0] pkt_hdr_out,
    output logic [15:0] pkt_len_out,
    output logic [15:0] drop_count_out
);

    localparam int unsigned MAX_N     = (BUF_BYTES - 8) / 4;
    localparam int unsigned CNT_W     = 16;
    localparam logic [31:0] SIZE_ADDR = BUF_BASE + 32'd4;
    localparam logic [31:0] DATA_ADDR = BUF_BASE + 32'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIZE,
        ST_PAYLOAD,
        ST_DROP,
        ST_NOTIFY
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   idx_q;
    logic [CNT_W-1:0]   idx_d;
    logic               xfer;
    logic [CNT_W-1:0]   size_n;
    logic               size_too_big;
    logic               wr_en_d;
    logic [31:0]        wr_addr_d;
    logic [31:0]        wr_data_d;
    logic               irq_d;
    logic [31:0]        hdr_d;
    logic [15:0]        len_d;
    logic [15:0]        drop_d;
    logic               ready_d;

    // Handshake and size decode of the current flit.
    always_comb begin
        xfer         = rx_valid_in & rx_ready_out;
        size_n       = rx_data_in[15:0];
        size_too_big = 32'(size_n) > MAX_N;
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_nxt = state;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = mem_addr_out;
        wr_data_d = mem_data_out;
        irq_d     = irq_out;
        hdr_d     = pkt_hdr_out;
        len_d     = pkt_len_out;
        drop_d    = drop_count_out;

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BUF_BASE;
                    wr_data_d = rx_data_in;
                    hdr_d     = rx_data_in;
                    state_nxt = ST_SIZE;
                end
            end
            ST_SIZE: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = SIZE_ADDR;
                    wr_data_d = rx_data_in;
                    cnt_d     = size_n;
                    idx_d     = '0;
                    if (size_too_big) begin
                        // Oversized packet: count it and swallow the payload.
                        if (drop_count_out != 16'hFFFF) begin
                            drop_d = drop_count_out + 16'd1;
                        end
                        state_nxt = ST_DROP;
                    end else if (size_n == '0) begin
                        len_d     = '0;
                        state_nxt = ST_NOTIFY;
                    end else begin
                        len_d     = size_n;
                        state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = DATA_ADDR + {14'd0, idx_q, 2'b00};
                    wr_data_d = rx_data_in;
                    idx_d     = idx_q + 16'd1;
                    cnt_d     = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_nxt = ST_NOTIFY;
                    end
                end
            end
            ST_DROP: begin
                if (xfer) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_NOTIFY: begin
                // The interrupt rises one cycle after entry, once the last write
                // has committed; an ack only counts after it is visible.
                if (irq_out && cpu_ack_in) begin
                    irq_d     = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    irq_d = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        ready_d = (state_nxt != ST_NOTIFY);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            rx_ready_out   <= 1'b0;
            mem_enable_out <= 1'b0;
            mem_wb_out     <= 4'h0;
            mem_addr_out   <= '0;
            mem_data_out   <= '0;
            irq_out        <= 1'b0;
            pkt_hdr_out    <= '0;
            pkt_len_out    <= '0;
            drop_count_out <= '0;
        end else begin
            state          <= state_nxt;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            rx_ready_out   <= ready_d;
            mem_enable_out <= wr_en_d;
            mem_wb_out     <= wr_en_d ? 4'hF : 4'h0;
            mem_addr_out   <= wr_addr_d;
            mem_data_out   <= wr_data_d;
            irq_out        <= irq_d;
            pkt_hdr_out    <= hdr_d;
            pkt_len_out    <= len_d;
            drop_count_out <= drop_d;
        end
    end

endmodule

// File: tb/tb_noc_rx_dma.sv
// Bench for noc_rx_dma: directed scenarios plus random packets, each checked
// against a packet-level model of the buffer layout and interrupt protocol.
module tb_noc_rx_dma;

    localparam logic [31:0] BASE  = 32'h0000_E000;
    localparam int          MAXN  = 254;
    localparam int          LIMIT = 2000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rx_data_in;
    logic        rx_valid_in;
    logic        rx_ready_out;
    logic        mem_enable_out;
    logic [3:0]  mem_wb_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic        irq_out;
    logic        cpu_ack_in;
    logic [31:0] pkt_hdr_out;
    logic [15:0] pkt_len_out;
    logic [15:0] drop_count_out;

    noc_rx_dma dut (
        .clock          (clock),
        .reset          (reset),
        .rx_data_in     (rx_data_in),
        .rx_valid_in    (rx_valid_in),
        .rx_ready_out   (rx_ready_out),
        .mem_enable_out (mem_enable_out),
        .mem_wb_out     (mem_wb_out),
        .mem_addr_out   (mem_addr_out),
        .mem_data_out   (mem_data_out),
        .irq_out        (irq_out),
        .cpu_ack_in     (cpu_ack_in),
        .pkt_hdr_out    (pkt_hdr_out),
        .pkt_len_out    (pkt_len_out),
        .drop_count_out (drop_count_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Captured RAM writes and a byte-addressed image of the RAM.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_wb[$];
    int          wr_cyc[$];
    logic [7:0]  ram [logic [31:0]];

    always @(negedge clock) begin
        if (reset === 1'b1 && mem_enable_out === 1'b1) begin
            wr_addr.push_back(mem_addr_out);
            wr_data.push_back(mem_data_out);
            wr_wb.push_back(mem_wb_out);
            wr_cyc.push_back(cyc);
            ram[mem_addr_out]         = mem_data_out[31:24];
            ram[mem_addr_out + 32'd1] = mem_data_out[23:16];
            ram[mem_addr_out + 32'd2] = mem_data_out[15:8];
            ram[mem_addr_out + 32'd3] = mem_data_out[7:0];
        end
        if (reset === 1'b1 && mem_enable_out === 1'b0) begin
            total++;
            if (mem_wb_out !== 4'h0) begin
                bad++;
                $display("FAIL idle_strobe: got %h want 0", mem_wb_out);
            end
        end
    end

    // Stimulus data and model expectations.
    logic [31:0] pl_q[$];
    int          acc_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_idx[$];
    logic [15:0] exp_drop;
    logic [15:0] exp_len;

    // Expected buffer contents and status for one packet.
    task automatic model_pkt(input logic [31:0] hdr, input logic [31:0] size, output bit stored);
        int n;
        n = int'(size[15:0]);
        exp_addr.delete();
        exp_data.delete();
        exp_idx.delete();
        exp_addr.push_back(BASE);
        exp_data.push_back(hdr);
        exp_idx.push_back(0);
        exp_addr.push_back(BASE + 32'd4);
        exp_data.push_back(size);
        exp_idx.push_back(1);
        stored = (n <= MAXN);
        if (stored) begin
            for (int k = 0; k < n; k++) begin
                exp_addr.push_back(BASE + 32'(8 + 4 * k));
                exp_data.push_back(pl_q[k]);
                exp_idx.push_back(k + 2);
            end
            exp_len = 16'(n);
        end else if (exp_drop != 16'hFFFF) begin
            exp_drop = exp_drop + 16'd1;
        end
    endtask

    // Offer one flit after some idle cycles; returns at the negedge after acceptance.
    task automatic push_flit(input logic [31:0] d, input int idle);
        int n;
        rx_valid_in = 1'b0;
        repeat (idle) @(negedge clock);
        rx_data_in  = d;
        rx_valid_in = 1'b1;
        n = 0;
        while (rx_ready_out !== 1'b1 && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        if (n >= LIMIT) begin
            total++;
            bad++;
            $display("FAIL flit_timeout: ready stuck at %b want 1", rx_ready_out);
            rx_valid_in = 1'b0;
            acc_q.push_back(-1);
        end else begin
            @(negedge clock);
            acc_q.push_back(cyc);
            rx_valid_in = 1'b0;
        end
    endtask

    task automatic clear_capture();
        wr_addr.delete();
        wr_data.delete();
        wr_wb.delete();
        wr_cyc.delete();
        acc_q.delete();
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] size, input int max_idle);
        clear_capture();
        push_flit(hdr, 0);
        push_flit(size, $urandom_range(0, max_idle));
        for (int k = 0; k < pl_q.size(); k++) begin
            push_flit(pl_q[k], $urandom_range(0, max_idle));
        end
    endtask

    task automatic ack_pulse();
        cpu_ack_in = 1'b1;
        @(negedge clock);
        cpu_ack_in = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        rx_valid_in = 1'b0;
        rx_data_in  = '0;
        cpu_ack_in  = 1'b0;
        #1 reset    = 1'b0;
        #10;
        total++;
        if ({rx_ready_out, mem_enable_out, mem_wb_out, irq_out} !== 7'd0 ||
            mem_addr_out !== 0 || mem_data_out !== 0 || pkt_hdr_out !== 0 ||
            pkt_len_out !== 0 || drop_count_out !== 0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b en=%b wb=%h irq=%b a=%h d=%h h=%h l=%h dc=%h want all 0",
                     rx_ready_out, mem_enable_out, mem_wb_out, irq_out, mem_addr_out,
                     mem_data_out, pkt_hdr_out, pkt_len_out, drop_count_out);
        end
        exp_drop = '0;
        exp_len  = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (rx_ready_out !== 1'b1 || irq_out !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_reset: got rdy=%b irq=%b want 1 0", rx_ready_out, irq_out);
        end
    endtask

    task automatic test_basic();
        bit stored;
        logic [31:0] a;
        pl_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        model_pkt(32'hCAFE_0102, 32'd3, stored);
        send_pkt(32'hCAFE_0102, 32'd3, 0);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL irq_early: got %b want 0", irq_out);
        end
        @(negedge clock);
        total++;
        if (irq_out !== 1'b1 || pkt_len_out !== 16'd3 || pkt_hdr_out !== 32'hCAFE_0102) begin
            bad++;
            $display("FAIL basic_notify: got irq=%b len=%0d hdr=%h want 1 3 cafe0102",
                     irq_out, pkt_len_out, pkt_hdr_out);
        end
        total++;
        if (wr_addr.size() != 5) begin
            bad++;
            $display("FAIL basic_wr_count: got %0d want 5", wr_addr.size());
        end
        for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
            total++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i] || wr_wb[i] !== 4'hF ||
                wr_cyc[i] !== wr_cyc[0] + i || wr_cyc[i] !== acc_q[exp_idx[i]]) begin
                bad++;
                $display("FAIL basic_wr%0d: got a=%h d=%h s=%h c=%0d want a=%h d=%h s=f c=%0d",
                         i, wr_addr[i], wr_data[i], wr_wb[i], wr_cyc[i],
                         exp_addr[i], exp_data[i], acc_q[exp_idx[i]]);
            end
        end
        for (int b = 0; b < 4; b++) begin
            a = 32'hE008 + 32'(b);
            total++;
            if (!ram.exists(a) || ram[a] !== 8'h11) begin
                bad++;
                $display("FAIL ram_byte_%h: got %h want 11", a, ram.exists(a) ? ram[a] : 8'hxx);
            end
        end
    endtask

    task automatic test_ack();
        bit stored;
        repeat (3) begin
            rx_data_in  = 32'h0BAD_F00D;
            rx_valid_in = 1'b1;
            @(negedge clock);
            total++;
            if (rx_ready_out !== 1'b0 || mem_enable_out !== 1'b0 || irq_out !== 1'b1) begin
                bad++;
                $display("FAIL hold_notify: got rdy=%b en=%b irq=%b want 0 0 1",
                         rx_ready_out, mem_enable_out, irq_out);
            end
        end
        ack_pulse();
        total++;
        if (irq_out !== 1'b0 || rx_ready_out !== 1'b1 || mem_enable_out !== 1'b0) begin
            bad++;
            $display("FAIL ack_edge: got irq=%b rdy=%b en=%b want 0 1 0", irq_out, rx_ready_out, mem_enable_out);
        end
        @(negedge clock);
        rx_valid_in = 1'b0;
        total++;
        if (mem_enable_out !== 1'b1 || mem_addr_out !== BASE || mem_data_out !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL second_hdr: got en=%b a=%h d=%h want 1 %h 0badf00d",
                     mem_enable_out, mem_addr_out, mem_data_out, BASE);
        end
        push_flit(32'h0000_0001, 0);
        push_flit(32'h5A5A_A5A5, 0);
        // Ack before the interrupt is visible must be ignored.
        ack_pulse();
        total++;
        if (irq_out !== 1'b1 || rx_ready_out !== 1'b0 || pkt_len_out !== 16'd1 ||
            pkt_hdr_out !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL early_ack: got irq=%b rdy=%b len=%0d hdr=%h want 1 0 1 0badf00d",
                     irq_out, rx_ready_out, pkt_len_out, pkt_hdr_out);
        end
        exp_len = 16'd1;
        ack_pulse();
        total++;
        if (irq_out !== 1'b0 || rx_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL late_ack: got irq=%b rdy=%b want 0 1", irq_out, rx_ready_out);
        end
        stored = 1'b0;
    endtask

    task automatic test_drop();
        bit stored;
        pl_q.delete();
        for (int k = 0; k < 255; k++) pl_q.push_back($urandom());
        model_pkt(32'hD0D0_0001, 32'h0000_00FF, stored);
        send_pkt(32'hD0D0_0001, 32'h0000_00FF, 0);
        @(negedge clock);
        total++;
        if (stored || irq_out !== 1'b0 || rx_ready_out !== 1'b1 || drop_count_out !== exp_drop ||
            pkt_len_out !== exp_len) begin
            bad++;
            $display("FAIL drop_status: got irq=%b rdy=%b dc=%0d len=%0d want 0 1 %0d %0d",
                     irq_out, rx_ready_out, drop_count_out, pkt_len_out, exp_drop, exp_len);
        end
        total++;
        if (wr_addr.size() != 2 || wr_addr[0] !== BASE || wr_addr[1] !== BASE + 32'd4) begin
            bad++;
            $display("FAIL drop_writes: got n=%0d want 2 at e000/e004", wr_addr.size());
        end
        pl_q.delete();
        for (int k = 0; k < 254; k++) pl_q.push_back($urandom());
        model_pkt(32'hF00D_0254, 32'd254, stored);
        send_pkt(32'hF00D_0254, 32'd254, 1);
        @(negedge clock);
        total++;
        if (irq_out !== 1'b1 || pkt_len_out !== 16'd254 || wr_addr.size() != 256 ||
            wr_addr[wr_addr.size() - 1] !== 32'hE3FC) begin
            bad++;
            $display("FAIL max_pkt: got irq=%b len=%0d n=%0d last=%h want 1 254 256 e3fc",
                     irq_out, pkt_len_out, wr_addr.size(), wr_addr[wr_addr.size() - 1]);
        end
        for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
            total++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i] || wr_cyc[i] !== acc_q[exp_idx[i]]) begin
                bad++;
                $display("FAIL max_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i, wr_addr[i],
                         wr_data[i], wr_cyc[i], exp_addr[i], exp_data[i], acc_q[exp_idx[i]]);
            end
        end
        ack_pulse();
    endtask

    task automatic test_zero_len();
        bit stored;
        pl_q.delete();
        model_pkt(32'h2222_0000, 32'hABCD_0000, stored);
        send_pkt(32'h2222_0000, 32'hABCD_0000, 0);
        total++;
        if (irq_out !== 1'b0 || rx_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL zero_entry: got irq=%b rdy=%b want 0 0", irq_out, rx_ready_out);
        end
        @(negedge clock);
        total++;
        if (!stored || irq_out !== 1'b1 || pkt_len_out !== 16'd0 || pkt_hdr_out !== 32'h2222_0000 ||
            wr_addr.size() != 2 || wr_data[1] !== 32'hABCD_0000 || wr_addr[1] !== BASE + 32'd4) begin
            bad++;
            $display("FAIL zero_len: got irq=%b len=%0d n=%0d want 1 0 2", irq_out, pkt_len_out, wr_addr.size());
        end
        ack_pulse();
    endtask

    task automatic test_gaps();
        bit stored;
        pl_q = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        model_pkt(32'h6A95_0004, 32'd4, stored);
        clear_capture();
        push_flit(32'h6A95_0004, 0);
        push_flit(32'd4, 0);
        for (int k = 0; k < 4; k++) push_flit(pl_q[k], 1);
        @(negedge clock);
        total++;
        if (wr_addr.size() != 6 || irq_out !== 1'b1) begin
            bad++;
            $display("FAIL gap_count: got n=%0d irq=%b want 6 1", wr_addr.size(), irq_out);
        end
        for (int i = 0; i < wr_addr.size() && i < 6; i++) begin
            total++;
            if (wr_addr[i] !== BASE + 32'(4 * i) || wr_data[i] !== exp_data[i] ||
                wr_cyc[i] !== acc_q[i] || (i >= 3 && wr_cyc[i] !== wr_cyc[i - 1] + 2)) begin
                bad++;
                $display("FAIL gap_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i, wr_addr[i],
                         wr_data[i], wr_cyc[i], BASE + 32'(4 * i), exp_data[i], acc_q[i]);
            end
        end
        ack_pulse();
    endtask

    task automatic test_random();
        bit          stored;
        logic [31:0] hdr;
        logic [31:0] size;
        int          n;
        int          sel;
        for (int p = 0; p < 10; p++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      n = 0;
            else if (sel == 1) n = 255 + $urandom_range(0, 40);
            else if (sel == 2) n = MAXN;
            else               n = $urandom_range(1, 20);
            hdr  = $urandom();
            size = {16'($urandom()), 16'(n)};
            pl_q.delete();
            for (int k = 0; k < n; k++) pl_q.push_back($urandom());
            model_pkt(hdr, size, stored);
            send_pkt(hdr, size, $urandom_range(0, 2));
            @(negedge clock);
            total++;
            if (irq_out !== stored || pkt_len_out !== exp_len || pkt_hdr_out !== hdr ||
                drop_count_out !== exp_drop) begin
                bad++;
                $display("FAIL rnd%0d_status: got irq=%b len=%0d hdr=%h dc=%0d want %b %0d %h %0d", p,
                         irq_out, pkt_len_out, pkt_hdr_out, drop_count_out, stored, exp_len, hdr, exp_drop);
            end
            total++;
            if (wr_addr.size() != exp_addr.size()) begin
                bad++;
                $display("FAIL rnd%0d_count: got %0d want %0d", p, wr_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
                total++;
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i] || wr_wb[i] !== 4'hF ||
                    wr_cyc[i] !== acc_q[exp_idx[i]]) begin
                    bad++;
                    $display("FAIL rnd%0d_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", p, i,
                             wr_addr[i], wr_data[i], wr_cyc[i], exp_addr[i], exp_data[i], acc_q[exp_idx[i]]);
                end
            end
            if (stored) begin
                ack_pulse();
                total++;
                if (irq_out !== 1'b0 || rx_ready_out !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd%0d_ack: got irq=%b rdy=%b want 0 1", p, irq_out, rx_ready_out);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit stored;
        clear_capture();
        push_flit(32'h7777_0005, 0);
        push_flit(32'd5, 0);
        push_flit(32'h1234_5678, 0);
        push_flit(32'h9ABC_DEF0, 0);
        reset = 1'b0;
        #1;
        total++;
        if ({rx_ready_out, mem_enable_out, mem_wb_out, irq_out} !== 7'd0 ||
            mem_addr_out !== 0 || mem_data_out !== 0 || pkt_hdr_out !== 0 ||
            pkt_len_out !== 0 || drop_count_out !== 0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got rdy=%b en=%b a=%h h=%h l=%h dc=%h want all 0",
                     rx_ready_out, mem_enable_out, mem_addr_out, pkt_hdr_out, pkt_len_out, drop_count_out);
        end
        exp_drop = '0;
        exp_len  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        pl_q = '{32'hFEED_0000, 32'hFEED_0001, 32'hFEED_0002};
        model_pkt(32'h8888_0003, 32'd3, stored);
        send_pkt(32'h8888_0003, 32'd3, 0);
        @(negedge clock);
        total++;
        if (irq_out !== 1'b1 || drop_count_out !== 16'd0 || pkt_len_out !== 16'd3 || wr_addr.size() != 5) begin
            bad++;
            $display("FAIL fresh_pkt: got irq=%b dc=%0d len=%0d n=%0d want 1 0 3 5",
                     irq_out, drop_count_out, pkt_len_out, wr_addr.size());
        end
        for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
            total++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                bad++;
                $display("FAIL fresh_wr%0d: got a=%h d=%h want a=%h d=%h", i, wr_addr[i], wr_data[i],
                         exp_addr[i], exp_data[i]);
            end
        end
        ack_pulse();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack();
        test_drop();
        test_zero_len();
        test_gaps();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
